// File: rtl/rgb_color_sequencer.sv
// Six-hue RGB wheel sequencer for a discrete RGB LED: hop mode hard-switches hues,
// fade mode cross-fades adjacent hues with per-channel PWM. All pins are registered.
module rgb_color_sequencer #(
    parameter int STEP_CYCLES      = 2000000,
    parameter int FADE_STEP_CYCLES = 7843,
    parameter int PWM_BITS         = 8,
    parameter int ACTIVE_LOW       = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       mode,
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B,
    output logic [2:0] hue_idx,
    output logic       seg_tick
);

    localparam int MAX_CYC = (STEP_CYCLES > FADE_STEP_CYCLES) ? STEP_CYCLES : FADE_STEP_CYCLES;
    localparam int PRE_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [PRE_W-1:0]    HOP_TERM  = PRE_W'(STEP_CYCLES - 1);
    localparam logic [PRE_W-1:0]    FADE_TERM = PRE_W'(FADE_STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
    localparam logic                DARK      = (ACTIVE_LOW != 0);

    typedef enum logic [2:0] {
        HUE_RED     = 3'd0,
        HUE_YELLOW  = 3'd1,
        HUE_GREEN   = 3'd2,
        HUE_CYAN    = 3'd3,
        HUE_BLUE    = 3'd4,
        HUE_MAGENTA = 3'd5
    } hue_t;

    hue_t                      hue_reg, hue_next;
    logic [PRE_W-1:0]          pre_reg, pre_next;
    logic [PWM_BITS-1:0]       ramp_reg, ramp_next;
    logic [PWM_BITS-1:0]       pwm_reg;
    logic                      mode_reg;
    logic                      seg_tick_reg;
    logic [2:0]                pin_reg;

    logic [PRE_W-1:0]          term;
    logic                      mode_chg;
    logic                      tick;
    logic                      advance;
    logic [2:0][PWM_BITS-1:0]  level;
    logic [2:0]                lit;

    // Tick and advance qualification; a mode change suppresses both for one edge.
    always_comb begin
        term     = mode ? FADE_TERM : HOP_TERM;
        mode_chg = (mode != mode_reg);
        tick     = enable && !mode_chg && (pre_reg >= term);
        advance  = tick && (!mode || (ramp_reg == LVL_MAX));
    end

    always_comb begin
        pre_next = pre_reg;
        if (mode_chg) begin
            pre_next = '0;
        end else if (enable) begin
            pre_next = (pre_reg >= term) ? '0 : pre_reg + PRE_W'(1);
        end
    end

    always_comb begin
        ramp_next = ramp_reg;
        if (mode_chg) begin
            ramp_next = '0;
        end else if (tick && mode) begin
            ramp_next = ramp_reg + PWM_BITS'(1);
        end
    end

    always_comb begin
        hue_next = hue_reg;
        case (hue_reg)
            HUE_RED:     if (advance) hue_next = HUE_YELLOW;
            HUE_YELLOW:  if (advance) hue_next = HUE_GREEN;
            HUE_GREEN:   if (advance) hue_next = HUE_CYAN;
            HUE_CYAN:    if (advance) hue_next = HUE_BLUE;
            HUE_BLUE:    if (advance) hue_next = HUE_MAGENTA;
            HUE_MAGENTA: if (advance) hue_next = HUE_RED;
            default:     hue_next = HUE_RED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hue_reg      <= HUE_RED;
            pre_reg      <= '0;
            ramp_reg     <= '0;
            pwm_reg      <= '0;
            mode_reg     <= 1'b0;
            seg_tick_reg <= 1'b0;
        end else begin
            hue_reg      <= hue_next;
            pre_reg      <= pre_next;
            ramp_reg     <= ramp_next;
            pwm_reg      <= pwm_reg + PWM_BITS'(1);
            mode_reg     <= mode;
            seg_tick_reg <= advance;
        end
    end

    // Channel levels, index 0=R 1=G 2=B; fade overrides the one moving channel.
    always_comb begin
        level = '0;
        case (hue_reg)
            HUE_RED:     level[0] = LVL_MAX;
            HUE_YELLOW:  begin level[0] = LVL_MAX; level[1] = LVL_MAX; end
            HUE_GREEN:   level[1] = LVL_MAX;
            HUE_CYAN:    begin level[1] = LVL_MAX; level[2] = LVL_MAX; end
            HUE_BLUE:    level[2] = LVL_MAX;
            HUE_MAGENTA: begin level[0] = LVL_MAX; level[2] = LVL_MAX; end
            default:     level = '0;
        endcase
        if (mode) begin
            case (hue_reg)
                HUE_RED:     level[1] = ramp_reg;
                HUE_YELLOW:  level[0] = LVL_MAX - ramp_reg;
                HUE_GREEN:   level[2] = ramp_reg;
                HUE_CYAN:    level[1] = LVL_MAX - ramp_reg;
                HUE_BLUE:    level[0] = ramp_reg;
                HUE_MAGENTA: level[2] = LVL_MAX - ramp_reg;
                default:     level = '0;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_ch
            assign lit[gi] = (level[gi] == LVL_MAX) || (pwm_reg < level[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_reg <= {3{DARK}};
        end else begin
            pin_reg <= lit ^ {3{DARK}};
        end
    end

    assign RGB_R    = pin_reg[0];
    assign RGB_G    = pin_reg[1];
    assign RGB_B    = pin_reg[2];
    assign hue_idx  = hue_reg;
    assign seg_tick = seg_tick_reg;

endmodule

// File: tb/tb_rgb_color_sequencer.sv
// Directed bench for rgb_color_sequencer: hop wheel, freeze, fade PWM, mode switch,
// asynchronous reset and pin polarity, with hand-computed expectations.
module tb_rgb_color_sequencer;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b0;
    logic       mode   = 1'b0;
    logic       r, g, b, seg;
    logic [2:0] hue;
    logic       pr, pg, pb, pseg;
    logic [2:0] phue;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rgb_color_sequencer #(
        .STEP_CYCLES(4), .FADE_STEP_CYCLES(1), .PWM_BITS(2), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .RGB_R(r), .RGB_G(g), .RGB_B(b), .hue_idx(hue), .seg_tick(seg)
    );

    rgb_color_sequencer #(
        .STEP_CYCLES(4), .FADE_STEP_CYCLES(1), .PWM_BITS(2), .ACTIVE_LOW(0)
    ) dut_pol (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .RGB_R(pr), .RGB_G(pg), .RGB_B(pb), .hue_idx(phue), .seg_tick(pseg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Active-low {R,G,B} for each hue in hop mode.
    function automatic logic [2:0] hop_pins(input int h);
        case (h)
            0:       return 3'b011;
            1:       return 3'b001;
            2:       return 3'b101;
            3:       return 3'b100;
            4:       return 3'b110;
            default: return 3'b010;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; mode = 1'b0; enable = 1'b1;
        step(); step();
        tests++;
        if ({r, g, b} !== 3'b111) begin fails++; $display("FAIL reset_pins got %b exp 111", {r, g, b}); end
        tests++;
        if (hue !== 3'd0) begin fails++; $display("FAIL reset_hue got %0d exp 0", hue); end
        tests++;
        if (seg !== 1'b0) begin fails++; $display("FAIL reset_seg got %b exp 0", seg); end
        rst_n = 1'b1;
        step();
        tests++;
        if ({r, g, b} !== 3'b011) begin fails++; $display("FAIL first_edge_pins got %b exp 011", {r, g, b}); end
        $display("[TB] reset: pins=%b hue=%0d", {r, g, b}, hue);
    endtask

    task automatic test_hop_wheel();
        for (int k = 2; k <= 28; k++) begin
            logic [2:0] eh, ep;
            logic       es;
            step();
            eh = 3'((k / 4) % 6);
            es = (k % 4 == 0);
            ep = hop_pins(((k - 1) / 4) % 6);
            tests++;
            if (hue !== eh || seg !== es) begin
                fails++;
                $display("FAIL hop_hue k=%0d got hue=%0d seg=%b exp hue=%0d seg=%b", k, hue, seg, eh, es);
            end
            tests++;
            if ({r, g, b} !== ep) begin
                fails++;
                $display("FAIL hop_pins k=%0d got %b exp %b", k, {r, g, b}, ep);
            end
        end
        $display("[TB] hop wheel: ended hue=%0d", hue);
    endtask

    task automatic test_freeze();
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (hue == 3'd2 && seg == 1'b1) found = 1;
        end
        tests++;
        if (!found) begin fails++; $display("FAIL freeze_wait got no hue 2 advance exp one within 20 cycles"); end
        step();
        enable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            tests++;
            if ({hue, seg, r, g, b} !== {3'd2, 1'b0, 3'b101}) begin
                fails++;
                $display("FAIL freeze_hold i=%0d got hue=%0d seg=%b pins=%b exp hue=2 seg=0 pins=101", i, hue, seg, {r, g, b});
            end
        end
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            tests++;
            if ((i < 3 && {hue, seg} !== {3'd2, 1'b0}) || (i == 3 && {hue, seg} !== {3'd3, 1'b1})) begin
                fails++;
                $display("FAIL freeze_resume i=%0d got hue=%0d seg=%b", i, hue, seg);
            end
        end
        $display("[TB] freeze: resumed hue=%0d", hue);
    endtask

    task automatic test_enable_at_terminal();
        for (int i = 0; i < 3; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if ({hue, seg} !== {3'd3, 1'b0}) begin
                fails++;
                $display("FAIL term_hold i=%0d got hue=%0d seg=%b exp hue=3 seg=0", i, hue, seg);
            end
        end
        enable = 1'b1;
        step();
        tests++;
        if ({hue, seg} !== {3'd4, 1'b1}) begin
            fails++;
            $display("FAIL term_fire got hue=%0d seg=%b exp hue=4 seg=1", hue, seg);
        end
        $display("[TB] enable at terminal: hue=%0d seg=%b", hue, seg);
    endtask

    task automatic test_reset_midrun();
        step(); step();
        tests++;
        if ({r, g, b} !== 3'b110) begin fails++; $display("FAIL midrun_pre got %b exp 110", {r, g, b}); end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({r, g, b, hue, seg} !== {3'b111, 3'd0, 1'b0}) begin
            fails++;
            $display("FAIL midrun_async got pins=%b hue=%0d seg=%b exp pins=111 hue=0 seg=0", {r, g, b}, hue, seg);
        end
        step();
        $display("[TB] reset mid-run: pins=%b hue=%0d", {r, g, b}, hue);
    endtask

    task automatic test_fade();
        int  g_lit = 0;
        bit  r_ok = 1, b_ok = 1;
        mode = 1'b1; enable = 1'b1; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        tests++;
        if ({r, g, b, hue} !== {3'b011, 3'd0}) begin
            fails++;
            $display("FAIL fade_start got pins=%b hue=%0d exp pins=011 hue=0", {r, g, b}, hue);
        end
        step();
        enable = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            if (g == 1'b0) g_lit++;
            if (r !== 1'b0) r_ok = 0;
            if (b !== 1'b1) b_ok = 0;
        end
        tests++;
        if (g_lit != 2) begin fails++; $display("FAIL fade_g_duty got %0d lit of 8 exp 2", g_lit); end
        tests++;
        if (!r_ok) begin fails++; $display("FAIL fade_r_lit got red dark at least once exp always lit"); end
        tests++;
        if (!b_ok) begin fails++; $display("FAIL fade_b_dark got blue lit at least once exp always dark"); end
        enable = 1'b1;
        for (int n = 1; n <= 26; n++) begin
            logic [2:0] eh;
            logic       es;
            step();
            eh = (n < 3) ? 3'd0 : 3'(((n - 3) / 4 + 1) % 6);
            es = (n >= 3) && ((n - 3) % 4 == 0);
            tests++;
            if ({hue, seg} !== {eh, es}) begin
                fails++;
                $display("FAIL fade_wheel n=%0d got hue=%0d seg=%b exp hue=%0d seg=%b", n, hue, seg, eh, es);
            end
        end
        $display("[TB] fade: g_lit=%0d hue=%0d", g_lit, hue);
    endtask

    task automatic test_mode_switch();
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (hue == 3'd4 && seg == 1'b1) found = 1;
        end
        tests++;
        if (!found) begin fails++; $display("FAIL switch_wait got no hue 4 advance exp one within 40 cycles"); end
        step(); step();
        tests++;
        if (dut.ramp_reg !== 2'd2) begin fails++; $display("FAIL switch_ramp_pre got %0d exp 2", dut.ramp_reg); end
        mode = 1'b0;
        step();
        tests++;
        if ({hue, seg, dut.ramp_reg} !== {3'd4, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL switch_clear got hue=%0d seg=%b ramp=%0d exp hue=4 seg=0 ramp=0", hue, seg, dut.ramp_reg);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            tests++;
            if ((i < 4 && {hue, seg} !== {3'd4, 1'b0}) || (i == 4 && {hue, seg} !== {3'd5, 1'b1})) begin
                fails++;
                $display("FAIL switch_advance i=%0d got hue=%0d seg=%b", i, hue, seg);
            end
            if (i == 2) begin
                tests++;
                if ({r, g, b} !== 3'b110) begin fails++; $display("FAIL switch_pins got %b exp 110", {r, g, b}); end
            end
        end
        $display("[TB] mode switch: hue=%0d", hue);
    endtask

    task automatic test_polarity();
        mode = 1'b0; enable = 1'b1; rst_n = 1'b0;
        step();
        tests++;
        if ({pr, pg, pb} !== 3'b000) begin fails++; $display("FAIL pol_reset got %b exp 000", {pr, pg, pb}); end
        rst_n = 1'b1;
        step();
        tests++;
        if ({pr, pg, pb, phue} !== {3'b100, 3'd0}) begin
            fails++;
            $display("FAIL pol_red got pins=%b hue=%0d exp pins=100 hue=0", {pr, pg, pb}, phue);
        end
        for (int i = 0; i < 4; i++) step();
        tests++;
        if ({pr, pg, pb, phue} !== {3'b110, 3'd1}) begin
            fails++;
            $display("FAIL pol_yellow got pins=%b hue=%0d exp pins=110 hue=1", {pr, pg, pb}, phue);
        end
        $display("[TB] polarity: pins=%b hue=%0d", {pr, pg, pb}, phue);
    endtask

    initial begin
        test_reset();
        test_hop_wheel();
        test_freeze();
        test_enable_at_terminal();
        test_reset_midrun();
        test_fade();
        test_mode_switch();
        test_polarity();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rgb_color_sequencer.md
# rgb_color_sequencer

Parametrised RGB colour sequencer for the board's common-anode RGB LED. It steps through the six-hue wheel (red, yellow, green, cyan, blue, magenta) in one of two modes. Hop mode jumps between hues at a fixed interval. Fade mode cross-fades between adjacent hues using per-channel PWM. It sits directly between the 12 MHz board clock and the RGB_R/RGB_G/RGB_B pins and supersedes the fixed-interval hard-switching colour cycler.

## Interface
- STEP_CYCLES, default 2000000: clock cycles per hue in hop mode (1/6 s at 12 MHz); must be ≥ 2.
- FADE_STEP_CYCLES, default 7843: clock cycles per ramp increment in fade mode; must be ≥ 1.
- PWM_BITS, default 8: PWM resolution. MAX = 2^PWM_BITS − 1.
- ACTIVE_LOW, default 1: 1 means a pin driven 0 lights the LED; 0 means a pin driven 1 lights it.
- clk in 1: single system clock; all state is on its rising edge.
- rst_n in 1: asynchronous, active-low reset.
- enable in 1: 1 lets the sequence advance; 0 freezes the hue and ramp.
- mode in 1: 0 selects hop, 1 selects fade.
- RGB_R out 1: red pin, registered, polarity per ACTIVE_LOW.
- RGB_G out 1: green pin, registered.
- RGB_B out 1: blue pin, registered.
- hue_idx out 3: current hue, 0=red, 1=yellow, 2=green, 3=cyan, 4=blue, 5=magenta.
- seg_tick out 1: one-cycle pulse on the cycle hue_idx advances.

## Operation
- Hue state is 0..5. From 5 it wraps to 0; values 6 and 7 are unreachable and, if ever entered, go to 0 on the next edge.
- Prescaler counter:
  - Terminal count is STEP_CYCLES−1 in hop mode and FADE_STEP_CYCLES−1 in fade mode.
  - At terminal count it clears to 0 and asserts an internal tick.
  - Width is $clog2 of the larger parameter.
- Hop mode:
  - On tick, the hue advances and seg_tick pulses.
  - Channel levels are MAX or 0 per hue. Red: R only. Yellow: R+G. Green: G. Cyan: G+B. Blue: B. Magenta: R+B.
- Fade mode:
  - A ramp counter of PWM_BITS width runs 0..MAX, incrementing on each tick.
  - On a tick with ramp==MAX, ramp goes to 0, the hue advances and seg_tick pulses.
  - Exactly one channel moves per hue; the other channels hold their hop-mode levels.
    - Red: G = ramp (rising).
    - Yellow: R = MAX−ramp (falling).
    - Green: B = ramp.
    - Cyan: G = MAX−ramp.
    - Blue: R = ramp.
    - Magenta: B = MAX−ramp.
  - Levels are continuous across hue boundaries.
- PWM:
  - pwm_cnt is PWM_BITS wide, free-runs every cycle and wraps MAX→0, independent of enable and mode.
  - A channel is lit when level==MAX or pwm_cnt < level.
  - Level 0 is always dark; level MAX is always lit.
- Pin value = lit XOR ACTIVE_LOW, registered.
- enable=0: the prescaler, ramp and hue hold and seg_tick stays 0. PWM continues, so the displayed colour is held.
- A change on mode, detected by a registered compare, clears the prescaler and ramp on the following edge. hue_idx is retained. No seg_tick is generated by the switch.

## Timing
- Reset (rst_n=0, asynchronous) sets:
  - hue_idx=0, ramp=0, prescaler=0, pwm_cnt=0, seg_tick=0.
  - All pins dark: 1 when ACTIVE_LOW=1, 0 otherwise.
- First edge after rst_n rises: the pins take the red levels. In hop mode, RGB_R is lit from that edge onward.
- Hue and ramp update on the edge where tick is asserted. seg_tick is high for the cycle after that edge, aligned with the new hue_idx.
- Pins lag a level change by exactly one cycle.
- Hop period: exactly STEP_CYCLES cycles per hue and 6·STEP_CYCLES per full wheel while enable=1.
- Fade period: (MAX+1)·FADE_STEP_CYCLES cycles per hue.
- Reset asserted mid-sequence: immediate return to the reset values; no partial tick completes.
- If enable drops on the terminal-count cycle, no tick occurs and the prescaler holds at terminal count. The tick fires on the first enabled cycle afterwards.

## Test plan
- Reset, with ACTIVE_LOW=1 and STEP_CYCLES=4:
  - During reset, pins are 1/1/1 and hue_idx=0.
  - After release, RGB_R=0, RGB_G=1, RGB_B=1.
- Hop wheel, with mode=0 and STEP_CYCLES=4:
  - hue_idx runs 0,1,2,3,4,5,0, each value held 4 cycles, with seg_tick pulsing every 4 cycles.
  - Pin patterns per hue match the table, e.g. hue 3 gives R=1, G=0, B=0.
- Fade, with PWM_BITS=2 and FADE_STEP_CYCLES=1:
  - At hue 0 with ramp=1, RGB_G is lit 1 of every 4 cycles and RGB_R is always lit.
  - The hue advances every 4 cycles and wraps after 24.
- Freeze:
  - Drop enable at hue 2 for 50 cycles: hue_idx stays 2, seg_tick stays 0, and the pin pattern is unchanged.
  - After enable returns, the advance resumes with the remaining count.
- Mode switch and reset mid-run:
  - Switching mode 1→0 at hue 4 with ramp=2 keeps hue_idx=4, clears ramp, and the next advance comes STEP_CYCLES cycles later.
  - Asserting rst_n=0 mid-cycle drives all pins dark asynchronously.
- Polarity, with ACTIVE_LOW=0: at hue 0 after reset, RGB_R=1, RGB_G=0, RGB_B=0.
